// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - multi-cycle unsigned restoring divider controller
//
// rcs: w-bit ripple-borrow subtractor, diff = a - b - bin, bout = borrow out.
//
// div_seq_ctrl: sequences one (n+1)-bit rcs through n trial subtractions and
// produces one quotient bit per clock, MSB first.
//   clk          rising-edge clock
//   rst_n        synchronous reset, active-low
//   start        request, accepted only in IDLE or DONE
//   dividend     unsigned dividend, sampled on the accepting edge
//   divisor      unsigned divisor, sampled on the accepting edge
//   busy         high while iterating (RUN)
//   done         one-cycle pulse while results are fresh (DONE)
//   quotient     result register, held until the next result
//   remainder    result register, held until the next result
//   div_by_zero  flag for the current result, held with it

module rcs #(
    parameter int w = 9
) (
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    input  logic         bin,
    output logic [w-1:0] diff,
    output logic         bout
);
    logic [w:0] br;

    assign br[0] = bin;

    genvar i;
    generate
        for (i = 0; i < w; i++) begin : g_bit
            assign diff[i]  = a[i] ^ b[i] ^ br[i];
            assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
        end
    endgenerate

    assign bout = br[w];
endmodule

module div_seq_ctrl #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_by_zero
);
    localparam int CW = (n > 2) ? $clog2(n) : 1;
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [n:0]    r_acc;
    logic [n-1:0]  q_acc;
    logic [n-1:0]  d_reg;
    logic [CW-1:0] cnt;

    logic [n:0]    s_val;
    logic [n:0]    t_val;
    logic [n:0]    r_nx;
    logic [n-1:0]  q_nx;
    logic          bout;
    logic          accept;

    // Shift the next dividend bit into the partial remainder and try the subtract.
    assign s_val = {r_acc[n-1:0], q_acc[n-1]};

    rcs #(.w(n + 1)) u_rcs (
        .a    (s_val),
        .b    ({1'b0, d_reg}),
        .bin  (1'b0),
        .diff (t_val),
        .bout (bout)
    );

    // Borrow means the trial failed: keep the shifted value (restore).
    assign r_nx   = bout ? s_val : t_val;
    assign q_nx   = {q_acc[n-2:0], ~bout};
    assign accept = start && ((state == IDLE) || (state == DONE));

    // The partial remainder never exceeds n bits, so its top bit is never read.
    logic unused_r_msb;
    assign unused_r_msb = r_acc[n];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            r_acc       <= '0;
            q_acc       <= '0;
            d_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                r_acc <= '0;
                q_acc <= dividend;
                d_reg <= divisor;
                cnt   <= '0;
                // Zero divisor skips RUN, so its result is loaded right here.
                if (divisor == '0) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end
            end else if (state == RUN) begin
                r_acc <= r_nx;
                q_acc <= q_nx;
                cnt   <= cnt + 1'b1;
                if (cnt == LAST) begin
                    quotient    <= q_nx;
                    remainder   <= r_nx[n-1:0];
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nx = (divisor == '0) ? DONE : RUN;
                else       state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - scoreboard bench for div_seq_ctrl at n=8
module tb_div_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int fails  = 0;

    logic [16:0] exp_q [$];

    // {dividend, divisor, quotient, remainder, div_by_zero}
    logic [32:0] vec [5] = '{
        {8'd100, 8'd7,   8'd14,  8'd2,  1'b0},
        {8'd255, 8'd1,   8'd255, 8'd0,  1'b0},
        {8'd5,   8'd9,   8'd0,   8'd5,  1'b0},
        {8'd255, 8'd255, 8'd1,   8'd0,  1'b0},
        {8'd42,  8'd0,   8'hFF,  8'd42, 1'b1}
    };

    div_seq_ctrl #(.n(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("quotient",    {24'd0, quotient},  {24'd0, e[16:9]});
                chk("remainder",   {24'd0, remainder}, {24'd0, e[8:1]});
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e[0]});
            end
        end
    end

    // Called #1 after the accepting edge; counts edges until done and busy cycles.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic ez);
        int lat, bcnt;
        exp_q.push_back({eq, er, ez});
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("latency",    lat,  (b == 8'd0) ? 0 : 8);
        chk("busy_count", bcnt, (b == 8'd0) ? 0 : 8);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, bcnt, ndone;
        logic [7:0] a, b;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   {31'd0, busy}, 0);
        chk("rst_done",   {31'd0, done}, 0);
        chk("rst_quot",   {24'd0, quotient}, 0);
        chk("rst_rem",    {24'd0, remainder}, 0);
        chk("rst_dbz",    {31'd0, div_by_zero}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, each started from IDLE.
        for (int i = 0; i < 5; i++) begin
            logic [32:0] v;
            v = vec[i];
            run_op(v[32:25], v[24:17], v[16:9], v[8:1], v[0]);
        end

        // start held through RUN with other operands, then back-to-back accept in DONE.
        exp_q.push_back({8'd14, 8'd2, 1'b0});
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk); #1;
        dividend = 8'd1;
        divisor  = 8'd1;
        wait_done(lat, bcnt);
        chk("held_latency", lat, 8);
        chk("held_busy",    bcnt, 8);
        exp_q.push_back({8'd66, 8'd2, 1'b0});
        dividend = 8'd200;
        divisor  = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("b2b_latency", lat, 8);
        chk("b2b_busy",    bcnt, 8);
        @(posedge clk); #1;

        // Reset landing on the 4th iteration edge aborts silently.
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_quot", {24'd0, quotient}, 0);
        chk("abort_rem",  {24'd0, remainder}, 0);
        chk("abort_dbz",  {31'd0, div_by_zero}, 0);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        // Random operations against a behavioural / and % model.
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = (i % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (b == 8'd0) run_op(a, b, 8'hFF, a, 1'b1);
            else           run_op(a, b, a / b, a % b, 1'b0);
        end

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
